debounced_input_pio: RTL
========================

// Module: debounced_input_pio
// PURPOSE
//  Avalon-MM input port: the read-side counterpart of the LCD/control output PIOs.
//  Samples WIDTH external lines (front-panel buttons, encoder, LCD status), synchronises and
//  debounces each bit, captures debounced edges and raises an edge interrupt to the Nios II.
//  Register map: 0 data, 2 irq mask, 3 edge capture. Software polls these registers or services the IRQ.
// PARAMETERS
//  WIDTH            5      number of input lines (1..32)
//  SYNC_STAGES      2      synchroniser flops per bit (>=2)
//  DEBOUNCE_CYCLES  50000  cycles a new level must hold before acceptance (>=1; 1 ms @ 50 MHz)
//  EDGE_TYPE        0      captured edge: 0 rising, 1 falling, 2 any
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  address     in   3      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  readdata    out  32     read data, zero-extended
//  in_port     in   WIDTH  raw asynchronous inputs
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Reset: all sync flops, deb, deb_prev, counters, irq_mask and edge_cap = 0; readdata = 0; irq = 0.
//  Reset is effective immediately, also mid-debounce; after release a full DEBOUNCE_CYCLES is required.
//  Sync: in_port passes through SYNC_STAGES flops -> sync[i].
//  Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
//   sync==deb -> cnt<=0.
//   sync!=deb and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
//   sync!=deb and cnt==DEBOUNCE_CYCLES-1 -> deb<=sync, cnt<=0.
//   Any return to the deb level restarts the count; the counter never wraps.
//   Pulses shorter than DEBOUNCE_CYCLES are discarded.
//  Latency: stable in_port change -> deb change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
//  deb resets to 0, so a line held high through reset produces a rising edge after that latency.
//  Edge: deb_prev<=deb every cycle.
//   edge = deb&~deb_prev (0), ~deb&deb_prev (1), deb^deb_prev (2).
//  edge_cap[i]: set by edge[i]; cleared by a write to address 3 with writedata[i]=1.
//   A set and a clear in the same cycle leave the bit at 1 (set wins).
//  irq_mask: written from writedata[WIDTH-1:0] at address 3'd2.
//  Writes (chipselect & ~write_n):
//   address 0 ignored (read-only); addresses 1, 4-7 ignored.
//  Reads are combinational, read latency 0, not gated by chipselect:
//   address 0 -> deb; 2 -> irq_mask; 3 -> edge_cap; other addresses -> 0.
//   readdata[31:WIDTH] = 0.
//  irq = |(edge_cap & irq_mask), driven from registers with no added latency.
//   Deasserts the cycle after the clearing write or mask write.
// TESTING
//  (WIDTH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=16, EDGE_TYPE=0 unless noted)
//  1 Reset: pulse reset; read addresses 0-7 -> all 0x00000000, irq=0.
//  2 Bounce: in_port[0] toggles 4 times at 5-cycle spacing, then holds 1
//    -> addr0 reads 0x01 exactly 18 cycles after the final transition; addr3 reads 0x01 (one edge).
//  3 Glitch: 15-cycle high pulse on in_port[2] -> addr0 stays 0x00, addr3 stays 0x00, irq stays 0.
//  4 IRQ, mask 0x01: edge on bit0 -> irq=1; write 0x01 to addr3 -> irq=0 next cycle.
//    Mask 0x00 with edge on bit1 -> addr3=0x02, irq=0.
//  5 Race: addr3 clear of bit0 in the same cycle as a new bit0 edge -> addr3 reads 0x01, irq stays 1.
//  6 Mid-count reset: assert reset when cnt[0]=10 -> deb, cnt, mask, capture cleared.
//    After release with in_port[0]=1 held, deb[0] rises 18 cycles later.
//    EDGE_TYPE=2 rerun: both edges are captured.

Source files
------------

// File: rtl/debounced_input_pio.sv
// Avalon-MM input PIO: synchronises and debounces WIDTH raw lines, captures
// debounced edges and raises a maskable level interrupt.
module debounced_input_pio #(
    parameter int WIDTH           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic             wr_en, mask_wr, cap_clr;
    logic             unused_wdata;

    assign sync_w       = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A differing level must persist DEBOUNCE_CYCLES consecutive cycles; any
    // return to the accepted level restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_w[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_w[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = deb_q & ~deb_prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~deb_q & deb_prev_q;
        end else begin
            edge_det = deb_q ^ deb_prev_q;
        end
    end

    assign wr_en   = chipselect & ~write_n;
    assign mask_wr = wr_en && (address == 3'd2);
    assign cap_clr = wr_en && (address == 3'd3);

    // New edges are OR-ed in after the clear so a coincident set survives.
    always_comb begin
        mask_d     = mask_wr ? writedata[WIDTH-1:0] : mask_q;
        edge_cap_d = edge_cap_q;
        if (cap_clr) begin
            edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
        end
        edge_cap_d = edge_cap_d | edge_det;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            deb_q      <= '0;
            deb_prev_q <= '0;
            mask_q     <= '0;
            edge_cap_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = deb_q;
            3'd2:    readdata[WIDTH-1:0] = mask_q;
            3'd3:    readdata[WIDTH-1:0] = edge_cap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_cap_q & mask_q);

endmodule
